nat_ingress_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing the single NAT engine stream input among N AXI-Stream requesters.

---
 rtl/nat_ingress_arbiter_pkg.sv | 11 +
 rtl/nat_ingress_arbiter_if.sv | 18 +
 rtl/nat_ingress_arbiter_skid.sv | 75 +++++++
 rtl/nat_ingress_arbiter.sv | 129 ++++++++++++
 tb/tb_nat_ingress_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nat_ingress_arbiter_pkg.sv
// Shared constants for the NAT ingress arbiter: default stream widths and
// arbiter FSM state codes.
package nat_ingress_arbiter_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

endpackage

// File: rtl/nat_ingress_arbiter_if.sv
// AXI-Stream link from the arbiter into the NAT engine stream input.
interface nat_ingress_arbiter_if
  import nat_ingress_arbiter_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int KEEP_W = AXIS_KEEP_W
);

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/nat_ingress_arbiter_skid.sv
// Two-entry output skid buffer with registered outputs. The head register
// drives the output directly; the spare register catches the one beat that
// may still arrive after the consumer stalls.
module axis_skid_buf #(
  parameter int WIDTH = 73
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_push,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             full,
  output logic             empty
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] spare_q, spare_d;
  logic             pop;

  assign pop      = (cnt_q != 2'd0) && out_ready;
  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign out_data = head_q;

  // Next occupancy and storage contents from push/pop.
  always_comb begin
    cnt_d   = cnt_q;
    head_d  = head_q;
    spare_d = spare_q;
    case (cnt_q)
      2'd0: begin
        if (in_push) begin
          head_d = in_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (in_push && pop) begin
          head_d = in_data;
        end else if (in_push) begin
          spare_d = in_data;
          cnt_d   = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = spare_q;
          cnt_d  = 2'd1;
          if (in_push) begin
            spare_d = in_data;
            cnt_d   = 2'd2;
          end
        end
      end
    endcase
  end

  // Buffer state registers; reset empties the buffer and clears the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      head_q  <= '0;
      spare_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      spare_q <= spare_d;
    end
  end

endmodule

// File: rtl/nat_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding the NAT engine from N
// AXI-Stream requesters. A grant is held until the tlast beat of the granted
// port is accepted, so beats of different packets never interleave.
module nat_ingress_arbiter
  import nat_ingress_arbiter_pkg::*;
#(
  parameter int  N_PORTS = 2,
  parameter int  DATA_W  = AXIS_DATA_W,
  parameter int  KEEP_W  = AXIS_KEEP_W,
  parameter int  CNT_W   = 32,
  localparam int GW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arb_en,
  input  logic [N_PORTS*DATA_W-1:0]  s_axis_tdata,
  input  logic [N_PORTS*KEEP_W-1:0]  s_axis_tkeep,
  input  logic [N_PORTS-1:0]         s_axis_tlast,
  input  logic [N_PORTS-1:0]         s_axis_tvalid,
  output logic [N_PORTS-1:0]         s_axis_tready,
  nat_ingress_arbiter_if.master      m_axis,
  output logic [GW-1:0]              grant_id,
  output logic                       busy,
  output logic [N_PORTS*CNT_W-1:0]   pkt_cnt
);

  localparam int SKID_W = DATA_W + KEEP_W + 1;

  logic [0:0]                    state_q, state_d;
  logic [GW-1:0]                 grant_q, grant_d;
  logic [GW-1:0]                 last_q, last_d;
  logic [N_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]                 pick;
  logic [DATA_W-1:0]             g_data;
  logic [KEEP_W-1:0]             g_keep;
  logic                          g_last;
  logic                          g_valid;
  logic                          accept;
  logic                          skid_full;
  logic                          skid_empty;
  logic [SKID_W-1:0]             skid_out;

  // Round-robin pick: the requester closest after last_q wins; scanning from
  // the farthest distance down lets the nearest one overwrite the others.
  always_comb begin
    logic [GW:0] sum;
    sum  = '0;
    pick = last_q;
    for (int i = N_PORTS; i >= 1; i--) begin
      sum = {1'b0, last_q} + (GW+1)'(i);
      if (sum >= (GW+1)'(N_PORTS)) sum = sum - (GW+1)'(N_PORTS);
      if (s_axis_tvalid[sum[GW-1:0]]) pick = sum[GW-1:0];
    end
  end

  // Select the granted port's beat.
  always_comb begin
    g_data  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
    g_keep  = s_axis_tkeep[grant_q*KEEP_W +: KEEP_W];
    g_last  = s_axis_tlast[grant_q];
    g_valid = s_axis_tvalid[grant_q];
  end

  assign accept = (state_q == ARB_BUSY) && g_valid && !skid_full;

  // Only the granted port sees ready, and only while the skid has room.
  always_comb begin
    s_axis_tready = '0;
    if ((state_q == ARB_BUSY) && !skid_full) s_axis_tready[grant_q] = 1'b1;
  end

  // Grant on IDLE, release and count on the accepted tlast beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_en && (|s_axis_tvalid)) begin
          grant_d = pick;
          last_d  = pick;
          state_d = ARB_BUSY;
        end
      end
      default: begin
        if (accept && g_last) begin
          cnt_d[grant_q] = cnt_q[grant_q] + CNT_W'(1);
          state_d        = ARB_IDLE;
        end
      end
    endcase
  end

  // Arbiter state; last_q starts at the top port so port 0 is served first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  axis_skid_buf #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({g_last, g_keep, g_data}),
    .in_push   (accept),
    .out_data  (skid_out),
    .out_ready (m_axis.tready),
    .full      (skid_full),
    .empty     (skid_empty)
  );

  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = skid_out;
  assign m_axis.tvalid = !skid_empty;
  assign grant_id      = grant_q;
  assign busy          = (state_q == ARB_BUSY);
  assign pkt_cnt       = cnt_q;

endmodule

// File: tb/tb_nat_ingress_arbiter.sv
// Directed bench for nat_ingress_arbiter: per-port packet sources, a
// transaction-level scoreboard of accepted beats, and literal checkpoints.
module tb_nat_ingress_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic          l;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arb_en;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [0:0]      grant_id;
  logic            busy;
  logic [N*CW-1:0] pkt_cnt;
  logic            m_tready;

  nat_ingress_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) m_if ();
  assign m_if.tready = m_tready;

  nat_ingress_arbiter #(
    .N_PORTS (N),
    .DATA_W  (DW),
    .KEEP_W  (KW),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arb_en        (arb_en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis        (m_if),
    .grant_id      (grant_id),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  beat_t  src_q [N][$];
  beat_t  sb [$];
  logic [N-1:0] hs;
  int     m_busy, m_grant, m_last;
  int     m_cnt [N];
  int     acc [N];
  int     out_beats, out_lasts, last_pos, busy_samples;
  logic   prev_busy;
  int     grant_log [$];
  logic   rdy_mode;
  logic [7:0] rdy_pat;
  int     cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Next port by round-robin rule: first requester after 'last', wrapping.
  function automatic int rr(input int last, input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 1; i <= N; i++)
      if (r < 0 && v[(last + i) % N]) r = (last + i) % N;
    return r;
  endfunction

  // Per-cycle comparison against the scoreboard, then advance the model.
  task automatic compare();
    logic [N-1:0] exp_rdy;
    beat_t b;
    int nxt;
    if (!rst_n) begin
      m_busy = 0; m_grant = 0; m_last = N - 1;
      for (int p = 0; p < N; p++) m_cnt[p] = 0;
      sb.delete();
      hs = '0;
      prev_busy = 1'b0;
    end else begin
      exp_rdy = '0;
      if (m_busy != 0 && sb.size() < 2) exp_rdy[m_grant] = 1'b1;
      chk("s_tready", s_tready, exp_rdy);
      chk("busy", busy, m_busy);
      if (m_busy != 0) chk("grant_id", grant_id, m_grant);
      chk("m_tvalid", m_if.tvalid, sb.size() != 0);
      if (sb.size() != 0) begin
        chk("m_tdata", m_if.tdata, sb[0].d);
        chk("m_tkeep", m_if.tkeep, sb[0].k);
        chk("m_tlast", m_if.tlast, sb[0].l);
      end
      for (int p = 0; p < N; p++) chk("pkt_cnt", pkt_cnt[p*CW +: CW], m_cnt[p]);
      if (busy) busy_samples++;
      if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
      prev_busy = busy;

      hs = s_tvalid & s_tready;
      if (m_if.tvalid && m_tready && sb.size() != 0) begin
        b = sb.pop_front();
        out_beats++;
        if (b.l) begin
          out_lasts++;
          last_pos = out_beats;
        end
      end
      for (int p = 0; p < N; p++) begin
        if (hs[p]) begin
          b.d = s_tdata[p*DW +: DW];
          b.k = s_tkeep[p*KW +: KW];
          b.l = s_tlast[p];
          sb.push_back(b);
          acc[p]++;
        end
      end
      if (m_busy == 0) begin
        if (arb_en && (|s_tvalid)) begin
          nxt = rr(m_last, s_tvalid);
          m_busy = 1; m_grant = nxt; m_last = nxt;
        end
      end else if (hs[m_grant] && s_tlast[m_grant]) begin
        m_busy = 0;
        m_cnt[m_grant] = (m_cnt[m_grant] + 1) % (1 << CW);
      end
    end
  endtask

  task automatic present();
    beat_t b;
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() != 0) begin
        b = src_q[p][0];
        s_tdata[p*DW +: DW] = b.d;
        s_tkeep[p*KW +: KW] = b.k;
        s_tlast[p]  = b.l;
        s_tvalid[p] = 1'b1;
      end else begin
        s_tdata[p*DW +: DW] = '0;
        s_tkeep[p*KW +: KW] = '0;
        s_tlast[p]  = 1'b0;
        s_tvalid[p] = 1'b0;
      end
    end
  endtask

  // One clock: compare at negedge, then update sources after the posedge.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (!rst_n) src_q[p].delete();
      else if (hs[p] && src_q[p].size() != 0) b = src_q[p].pop_front();
    end
    present();
    m_tready = rdy_mode ? rdy_pat[cyc % 8] : 1'b1;
    cyc++;
  endtask

  task automatic load_pkt(input int port, input int nb, input int tag);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.l = (i == nb - 1);
      b.k = b.l ? 8'h3F : 8'hFF;
      b.d = {8'hE0, 8'(port), 16'(tag), 16'(i), 16'hC0DE};
      src_q[port].push_back(b);
    end
    present();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((src_q[0].size() != 0 || src_q[1].size() != 0 || sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", n < budget, 1'b1);
    tick();
    tick();
  endtask

  task automatic wait_acc(input int port, input int target, input int budget);
    int n;
    n = 0;
    while (acc[port] < target && n < budget) begin
      tick();
      n++;
    end
    chk("acc_reached", acc[port] >= target, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_tvalid"}, m_if.tvalid, 1'b0);
    chk({tag, "_m_tdata"}, m_if.tdata, '0);
    chk({tag, "_m_tkeep"}, m_if.tkeep, '0);
    chk({tag, "_m_tlast"}, m_if.tlast, 1'b0);
    chk({tag, "_s_tready"}, s_tready, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_grant_id"}, grant_id, '0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, '0);
  endtask

  initial begin
    int b0, b1, b2, n;
    rst_n = 1'b1; arb_en = 1'b1; m_tready = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0;
    hs = '0; rdy_mode = 1'b0; rdy_pat = 8'b1001_1011; cyc = 0;
    m_busy = 0; m_grant = 0; m_last = N - 1; prev_busy = 1'b0;
    out_beats = 0; out_lasts = 0; last_pos = 0; busy_samples = 0;
    for (int p = 0; p < N; p++) begin m_cnt[p] = 0; acc[p] = 0; end
    #3 rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst0");
    rst_n = 1'b1;
    tick();

    // 1: single 7-beat packet on port 0
    b0 = out_beats; b1 = out_lasts;
    load_pkt(0, 7, 1);
    wait_drain(200);
    chk("t1_beats", out_beats - b0, 7);
    chk("t1_lasts", out_lasts - b1, 1);
    chk("t1_last_pos", last_pos - b0, 7);
    chk("t1_pkt_cnt", pkt_cnt, 8'h01);

    // 2: both ports busy; last grant was port 0, so order is 1,0,1,0
    b0 = grant_log.size(); b1 = busy_samples;
    load_pkt(0, 7, 2); load_pkt(1, 7, 2);
    load_pkt(0, 7, 3); load_pkt(1, 7, 3);
    wait_drain(300);
    chk("t2_grants", grant_log.size() - b0, 4);
    chk("t2_g0", grant_log[b0], 1);
    chk("t2_g1", grant_log[b0 + 1], 0);
    chk("t2_g2", grant_log[b0 + 2], 1);
    chk("t2_g3", grant_log[b0 + 3], 0);
    chk("t2_busy_cycles", busy_samples - b1, 28);
    chk("t2_pkt_cnt", pkt_cnt, 8'h23);

    // 3: output back-pressure pattern
    rdy_mode = 1'b1;
    load_pkt(0, 7, 4); load_pkt(1, 5, 4);
    load_pkt(0, 3, 5); load_pkt(1, 7, 5);
    wait_drain(400);
    rdy_mode = 1'b0;
    tick();
    chk("t3_pkt_cnt", pkt_cnt, 8'h45);

    // 4: arb_en dropped on beat 3 of a port-1 packet
    b2 = acc[1];
    load_pkt(1, 7, 6);
    wait_acc(1, b2 + 2, 50);
    arb_en = 1'b0;
    load_pkt(0, 7, 6);
    n = 0;
    while ((src_q[1].size() != 0 || busy) && n < 50) begin tick(); n++; end
    chk("t4_pkt_done", n < 50, 1'b1);
    b1 = busy_samples;
    repeat (10) tick();
    chk("t4_no_grant", busy_samples - b1, 0);
    chk("t4_port0_held", src_q[0].size(), 7);
    chk("t4_pkt_cnt_mid", pkt_cnt, 8'h55);
    arb_en = 1'b1;
    wait_drain(200);
    chk("t4_pkt_cnt", pkt_cnt, 8'h56);

    // 5: reset in the middle of a packet (after beat 4)
    b2 = acc[0];
    load_pkt(0, 7, 7);
    wait_acc(0, b2 + 4, 50);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    load_pkt(1, 3, 8); load_pkt(0, 3, 8);
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    chk("t5_granted", busy, 1'b1);
    chk("t5_grant_port0", grant_id, 1'b0);
    wait_drain(200);
    chk("t5_pkt_cnt", pkt_cnt, 8'h11);

    // 6: counter wrap with single-beat packets on port 0
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) load_pkt(0, 1, 16 + i);
    wait_drain(400);
    chk("t6_wrap16", pkt_cnt, 8'h00);
    load_pkt(0, 1, 40);
    wait_drain(100);
    chk("t6_wrap17", pkt_cnt, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
